out_port_receiver: RTL and testbench

- Peripheral at the far end of the processor's output port.
- Captures every `outPortData` word that the Controller qualifies with `outSignalEn` and buffers it in a FIFO.
- Presents buffered words to an external sink over a valid/ready handshake.
- Flags loss on overflow and can optionally raise an interrupt back toward the Controller's `interruptSignal` input.

---
 rtl/out_port_receiver_pkg.sv | 10 +
 rtl/out_port_receiver_if.sv | 43 ++++
 rtl/out_port_fifo_ram.sv | 27 ++
 rtl/out_port_receiver.sv | 115 +++++++++++
 tb/tb_out_port_receiver.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/out_port_receiver_pkg.sv
// Shared constants for the output-port receiver: port word width (must track
// the Controller output port), default FIFO geometry and default IRQ threshold.
package out_port_receiver_pkg;

  localparam int DATA_W_DEF        = 16;
  localparam int DEPTH_DEF         = 8;
  localparam int PTR_W_DEF         = 3;
  localparam int IRQ_THRESHOLD_DEF = 4;

endpackage

// File: rtl/out_port_receiver_if.sv
// Bundle of the Controller-facing write port, the sink handshake and the
// status flags of the output-port receiver.
// Optional macro OUT_PORT_IRQ_EN adds the irqOut interrupt pulse.
interface out_port_receiver_if
  import out_port_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = PTR_W_DEF
);

  logic [DATA_W-1:0] outPortData;
  logic              outSignalEn;
  logic              sinkReady;
  logic              clearOverflow;
  logic [DATA_W-1:0] sinkData;
  logic              sinkValid;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef OUT_PORT_IRQ_EN
  logic              irqOut;
`endif

  // Receiver side
  modport slave (
    input  outPortData, outSignalEn, sinkReady, clearOverflow,
    output sinkData, sinkValid, count, full, empty, overflow
`ifdef OUT_PORT_IRQ_EN
    , output irqOut
`endif
  );

  // Controller / sink / bench side
  modport master (
    output outPortData, outSignalEn, sinkReady, clearOverflow,
    input  sinkData, sinkValid, count, full, empty, overflow
`ifdef OUT_PORT_IRQ_EN
    , input irqOut
`endif
  );

endinterface

// File: rtl/out_port_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module out_port_fifo_ram
  import out_port_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed entry on a qualified push
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_receiver.sv
// Output-port receiver: buffers every outSignalEn-qualified word from the
// Controller in a first-word-fall-through FIFO and hands them to a sink over
// valid/ready. Dropped writes on a full FIFO set a sticky overflow flag.
// Optional macro OUT_PORT_IRQ_EN adds a one-cycle irqOut pulse when the fill
// level rises across IRQ_THRESHOLD.
module out_port_receiver
  import out_port_receiver_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int PTR_W         = PTR_W_DEF
`ifdef OUT_PORT_IRQ_EN
  , parameter int IRQ_THRESHOLD = IRQ_THRESHOLD_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  out_port_receiver_if.slave bus
);

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);
`ifdef OUT_PORT_IRQ_EN
  localparam logic [PTR_W:0] IRQ_THR    = (PTR_W+1)'(IRQ_THRESHOLD);
`endif

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic              overflow_q, overflow_d;
`ifdef OUT_PORT_IRQ_EN
  logic              irq_q, irq_d;
`endif

  logic              full, empty, push, pop, drop;
  logic [DATA_W-1:0] ram_rdata;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.sinkReady;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign push  = bus.outSignalEn && (!full || pop);
  assign drop  = bus.outSignalEn && full && !pop;

  out_port_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.outPortData),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Next-state for pointers, fill level, sticky overflow and IRQ edge
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps by itself
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen together
    if (drop)                   overflow_d = 1'b1;
    else if (bus.clearOverflow) overflow_d = 1'b0;

`ifdef OUT_PORT_IRQ_EN
    // Pulse in the cycle right after the fill level rises across the threshold
    irq_d = (count_d >= IRQ_THR) && (count_q < IRQ_THR);
`endif
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef OUT_PORT_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef OUT_PORT_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  assign bus.sinkValid = !empty;
  assign bus.sinkData  = empty ? '0 : ram_rdata;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
`ifdef OUT_PORT_IRQ_EN
  assign bus.irqOut    = irq_q;
`endif

endmodule

// File: tb/tb_out_port_receiver.sv
// Directed bench for out_port_receiver. Inputs change and outputs are sampled
// on the falling clock edge. Optional macro OUT_PORT_IRQ_EN enables the
// interrupt checks.
module tb_out_port_receiver;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  out_port_receiver_if #(.DATA_W(16), .PTR_W(3)) bus ();

  out_port_receiver #(
    .DATA_W (16),
    .DEPTH  (8),
    .PTR_W  (3)
`ifdef OUT_PORT_IRQ_EN
    , .IRQ_THRESHOLD (4)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.outSignalEn = 1'b1;
    bus.outPortData = w;
    @(negedge clk);
    bus.outSignalEn = 1'b0;
    bus.outPortData = 16'h0000;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] w);
    bus.sinkReady = 1'b1;
    chk(tag, 32'(bus.sinkData), 32'(w));
    chk({tag, "_valid"}, 32'(bus.sinkValid), 32'd1);
    @(negedge clk);
    bus.sinkReady = 1'b0;
  endtask

  logic [15:0] vec4 [4];

  initial begin
    total = 0;
    bad   = 0;
    vec4[0] = 16'h0005; vec4[1] = 16'h0019; vec4[2] = 16'hFFFF; vec4[3] = 16'hF320;

    reset             = 1'b0;
    bus.outPortData   = 16'h1234;
    bus.outSignalEn   = 1'b0;
    bus.sinkReady     = 1'b0;
    bus.clearOverflow = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_count",    32'(bus.count),     32'd0);
    chk("rst_empty",    32'(bus.empty),     32'd1);
    chk("rst_full",     32'(bus.full),      32'd0);
    chk("rst_valid",    32'(bus.sinkValid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow),  32'd0);
    chk("rst_data",     32'(bus.sinkData),  32'd0);
`ifdef OUT_PORT_IRQ_EN
    chk("rst_irq",      32'(bus.irqOut),    32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Data with outSignalEn low must be ignored
    bus.outPortData = 16'hBEEF;
    @(negedge clk);
    chk("ignore_en0", 32'(bus.count), 32'd0);

    // Four writes, no sink
    push_word(vec4[0]);
    chk("lat1_valid", 32'(bus.sinkValid), 32'd1);
    chk("lat1_data",  32'(bus.sinkData),  32'h0005);
    for (int i = 1; i < 4; i++) push_word(vec4[i]);
    chk("w4_count", 32'(bus.count),     32'd4);
    chk("w4_data",  32'(bus.sinkData),  32'h0005);
    chk("w4_valid", 32'(bus.sinkValid), 32'd1);
    chk("w4_empty", 32'(bus.empty),     32'd0);
    chk("w4_full",  32'(bus.full),      32'd0);

    // Drain four in order
    for (int i = 0; i < 4; i++) pop_chk($sformatf("d4_%0d", i), vec4[i]);
    chk("d4_empty", 32'(bus.empty),     32'd1);
    chk("d4_valid", 32'(bus.sinkValid), 32'd0);

    // sinkReady while empty does nothing
    bus.sinkReady = 1'b1;
    @(negedge clk);
    bus.sinkReady = 1'b0;
    chk("rdy_empty_count", 32'(bus.count), 32'd0);

    // Overflow: nine writes into eight entries
    for (int i = 1; i <= 9; i++) push_word(16'(i));
    chk("ovf_full",  32'(bus.full),     32'd1);
    chk("ovf_count", 32'(bus.count),    32'd8);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    // Drop and clear together: set wins
    bus.outSignalEn   = 1'b1;
    bus.outPortData   = 16'h00EE;
    bus.clearOverflow = 1'b1;
    @(negedge clk);
    bus.outSignalEn   = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    bus.clearOverflow = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("ovf_d%0d", i), 16'(i));
    chk("ovf_drain_empty", 32'(bus.empty), 32'd1);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
    chk("pp_full_before", 32'(bus.full), 32'd1);
    bus.outSignalEn = 1'b1;
    bus.outPortData = 16'hABCD;
    bus.sinkReady   = 1'b1;
    chk("pp_head", 32'(bus.sinkData), 32'h0100);
    @(negedge clk);
    bus.outSignalEn = 1'b0;
    bus.sinkReady   = 1'b0;
    chk("pp_count",    32'(bus.count),    32'd8);
    chk("pp_overflow", 32'(bus.overflow), 32'd0);
    chk("pp_full",     32'(bus.full),     32'd1);
    for (int i = 1; i < 8; i++) pop_chk($sformatf("pp_d%0d", i), 16'h0100 + 16'(i));
    pop_chk("pp_last", 16'hABCD);
    chk("pp_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) push_word(16'h0A00 + 16'(i));
    chk("ar_count_before", 32'(bus.count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("ar_count",    32'(bus.count),     32'd0);
    chk("ar_valid",    32'(bus.sinkValid), 32'd0);
    chk("ar_overflow", 32'(bus.overflow),  32'd0);
    chk("ar_empty",    32'(bus.empty),     32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar_after_count", 32'(bus.count), 32'd0);

`ifdef OUT_PORT_IRQ_EN
    // Threshold crossing pulses once; re-arms after falling below
    for (int i = 1; i <= 3; i++) begin
      push_word(16'h0C00 + 16'(i));
      chk($sformatf("irq_w%0d", i), 32'(bus.irqOut), 32'd0);
    end
    push_word(16'h0C04);
    chk("irq_w4", 32'(bus.irqOut), 32'd1);
    push_word(16'h0C05);
    chk("irq_w5", 32'(bus.irqOut), 32'd0);
    @(negedge clk);
    chk("irq_idle", 32'(bus.irqOut), 32'd0);
    pop_chk("irq_p1", 16'h0C01);
    pop_chk("irq_p2", 16'h0C02);
    chk("irq_count3", 32'(bus.count),  32'd3);
    chk("irq_drain",  32'(bus.irqOut), 32'd0);
    push_word(16'h0C06);
    chk("irq_again", 32'(bus.irqOut), 32'd1);
    @(negedge clk);
    chk("irq_again_end", 32'(bus.irqOut), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
